// File: rtl/systolic_feeder.sv
// Systolic array edge feeder: buffers a DIM x DIM A/B operand pair,
// then streams skewed rows of A west and skewed columns of B north.
module systolic_feeder #(
  parameter int WIDTH = 32,
  parameter int DIM   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] in_a_row,
  input  logic [DIM*WIDTH-1:0] in_b_col,
  output logic [DIM*WIDTH-1:0] a_out,
  output logic [DIM*WIDTH-1:0] b_out,
  output logic                 stream_valid,
  output logic                 done,
  output logic                 busy
);

  localparam int KW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int TW    = $clog2(3 * DIM);
  localparam int TLAST = 3 * DIM - 3;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DONE
  } state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [TW-1:0]    t;
  logic [WIDTH-1:0] a_buf [DIM][DIM];
  logic [WIDTH-1:0] b_buf [DIM][DIM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      k     <= '0;
      t     <= '0;
      for (int i = 0; i < DIM; i++) begin
        for (int m = 0; m < DIM; m++) begin
          a_buf[i][m] <= '0;
          b_buf[i][m] <= '0;
        end
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            // beat k carries row k of A and column k of B
            for (int m = 0; m < DIM; m++) begin
              a_buf[k][m] <= in_a_row[m*WIDTH +: WIDTH];
              b_buf[m][k] <= in_b_col[m*WIDTH +: WIDTH];
            end
            if (k == KW'(DIM - 1)) begin
              k     <= '0;
              t     <= '0;
              state <= STREAM;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        STREAM: begin
          if (t == TW'(TLAST)) begin
            t     <= '0;
            state <= DONE;
          end else begin
            t <= t + TW'(1);
          end
        end
        DONE: begin
          state <= LOAD;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  assign in_ready     = (state == LOAD);
  assign stream_valid = (state == STREAM);
  assign done         = (state == DONE);
  assign busy         = (state != LOAD);

  // lane i shows element (i, t-i); t beyond 2*DIM-2 matches nothing
  always_comb begin
    a_out = '0;
    b_out = '0;
    if (state == STREAM) begin
      for (int i = 0; i < DIM; i++) begin
        for (int m = 0; m < DIM; m++) begin
          if (int'(t) == i + m) begin
            a_out[i*WIDTH +: WIDTH] = a_buf[i][m];
            b_out[i*WIDTH +: WIDTH] = b_buf[m][i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder against a matrix-level
// reference of the skewed edge streams.
module tb_systolic_feeder;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int NT = 3 * D - 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [D*W-1:0] in_a_row = '0;
  logic [D*W-1:0] in_b_col = '0;
  logic [D*W-1:0] a_out;
  logic [D*W-1:0] b_out;
  logic         stream_valid;
  logic         done;
  logic         busy;

  systolic_feeder #(.WIDTH(W), .DIM(D)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a_row(in_a_row),
    .in_b_col(in_b_col),
    .a_out(a_out),
    .b_out(b_out),
    .stream_valid(stream_valid),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0]   ma [D][D];
  logic [W-1:0]   mb [D][D];
  logic [D*W-1:0] a_cap [NT];
  logic [D*W-1:0] b_cap [NT];
  logic [D*W-1:0] a_ref [NT];
  logic [D*W-1:0] b_ref [NT];
  int busy_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D*W-1:0] rnd_vec();
    logic [D*W-1:0] r;
    for (int m = 0; m < D; m++) r[m*W +: W] = $urandom;
    return r;
  endfunction

  function automatic logic [D*W-1:0] row_a(int k);
    logic [D*W-1:0] r;
    for (int m = 0; m < D; m++) r[m*W +: W] = ma[k][m];
    return r;
  endfunction

  function automatic logic [D*W-1:0] col_b(int k);
    logic [D*W-1:0] r;
    for (int m = 0; m < D; m++) r[m*W +: W] = mb[m][k];
    return r;
  endfunction

  function automatic logic [D*W-1:0] exp_a(int t);
    logic [D*W-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      int c;
      c = t - i;
      if (t < 2*D-1 && c >= 0 && c < D) r[i*W +: W] = ma[i][c];
    end
    return r;
  endfunction

  function automatic logic [D*W-1:0] exp_b(int t);
    logic [D*W-1:0] r;
    r = '0;
    for (int j = 0; j < D; j++) begin
      int c;
      c = t - j;
      if (t < 2*D-1 && c >= 0 && c < D) r[j*W +: W] = mb[c][j];
    end
    return r;
  endfunction

  function automatic void set_directed();
    for (int i = 0; i < D; i++)
      for (int m = 0; m < D; m++) begin
        ma[i][m] = 16*i + m + 1;
        mb[i][m] = 100 + 16*i + m;
      end
  endfunction

  // mode 0: back-to-back, 1: valid toggles 1,0,1,0, 2: random gaps
  task automatic load(input int mode);
    int k;
    bit ph;
    bit v;
    k = 0;
    ph = 1'b1;
    while (k < D) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = ph;
      else v = ($urandom_range(0, 2) != 0);
      ph = ~ph;
      in_valid = v;
      in_a_row = v ? row_a(k) : rnd_vec();
      in_b_col = v ? col_b(k) : rnd_vec();
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready beat=%0d got %b want 1", k, in_ready);
      end
      step();
      if (v) k++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_stream(input string nm);
    busy_cnt = 0;
    for (int t = 0; t < NT; t++) begin
      in_valid = 1'b1;
      in_a_row = rnd_vec();
      in_b_col = rnd_vec();
      a_cap[t] = a_out;
      b_cap[t] = b_out;
      if (busy === 1'b1) busy_cnt++;
      n_checks++;
      if (a_out !== exp_a(t)) begin
        n_fail++;
        $display("FAIL %s a_out t=%0d got %h want %h", nm, t, a_out, exp_a(t));
      end
      n_checks++;
      if (b_out !== exp_b(t)) begin
        n_fail++;
        $display("FAIL %s b_out t=%0d got %h want %h", nm, t, b_out, exp_b(t));
      end
      n_checks++;
      if ({stream_valid, done, in_ready} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s sv/done/rdy t=%0d got %b want 100", nm, t,
                 {stream_valid, done, in_ready});
      end
      step();
    end
    in_valid = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    n_checks++;
    if ({stream_valid, done, in_ready} !== 3'b010 || a_out !== '0 || b_out !== '0) begin
      n_fail++;
      $display("FAIL %s done_cycle got sv/done/rdy=%b a=%h b=%h want 010,0,0", nm,
               {stream_valid, done, in_ready}, a_out, b_out);
    end
    step();
    n_checks++;
    if ({done, busy, in_ready, stream_valid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL %s back_to_load got done/busy/rdy/sv=%b want 0010", nm,
               {done, busy, in_ready, stream_valid});
    end
    n_checks++;
    if (busy_cnt != NT + 1) begin
      n_fail++;
      $display("FAIL %s busy_cycles got %0d want %0d", nm, busy_cnt, NT + 1);
    end
  endtask

  task automatic check_idle(input string nm);
    n_checks++;
    if ({in_ready, stream_valid, done, busy} !== 4'b1000 ||
        a_out !== '0 || b_out !== '0) begin
      n_fail++;
      $display("FAIL %s idle got rdy/sv/done/busy=%b a=%h b=%h want 1000,0,0", nm,
               {in_ready, stream_valid, done, busy}, a_out, b_out);
    end
  endtask

  task automatic compare_ref(input string nm);
    for (int t = 0; t < NT; t++) begin
      n_checks++;
      if (a_cap[t] !== a_ref[t] || b_cap[t] !== b_ref[t]) begin
        n_fail++;
        $display("FAIL %s repeat t=%0d got a=%h b=%h want a=%h b=%h", nm, t,
                 a_cap[t], b_cap[t], a_ref[t], b_ref[t]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    check_idle("reset_async");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check_idle("reset_release");
  endtask

  task automatic test_directed();
    set_directed();
    load(0);
    check_stream("directed");
    n_checks++;
    if (a_cap[0] !== {32'd0, 32'd0, 32'd0, 32'd1} ||
        b_cap[0] !== {32'd0, 32'd0, 32'd0, 32'd100}) begin
      n_fail++;
      $display("FAIL dir_t0 got a=%h b=%h want lane0 1/100", a_cap[0], b_cap[0]);
    end
    n_checks++;
    if (a_cap[3][3*W +: W] !== 32'd49 || b_cap[3][3*W +: W] !== 32'd103) begin
      n_fail++;
      $display("FAIL dir_t3 got a3=%0d b3=%0d want 49/103",
               a_cap[3][3*W +: W], b_cap[3][3*W +: W]);
    end
    n_checks++;
    if (a_cap[6][3*W +: W] !== 32'd52 || b_cap[6][3*W +: W] !== 32'd151) begin
      n_fail++;
      $display("FAIL dir_t6 got a3=%0d b3=%0d want 52/151",
               a_cap[6][3*W +: W], b_cap[6][3*W +: W]);
    end
    for (int t = 7; t < NT; t++) begin
      n_checks++;
      if (a_cap[t] !== '0 || b_cap[t] !== '0) begin
        n_fail++;
        $display("FAIL dir_drain t=%0d got a=%h b=%h want 0", t, a_cap[t], b_cap[t]);
      end
    end
    for (int t = 0; t < NT; t++) begin
      a_ref[t] = a_cap[t];
      b_ref[t] = b_cap[t];
    end
  endtask

  task automatic test_toggle();
    set_directed();
    load(1);
    check_stream("toggle");
    compare_ref("toggle");
  endtask

  task automatic test_back_to_back();
    logic rdy [20];
    int xfers;
    int low_run;
    int fifth;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      for (int m = 0; m < D; m++) begin
        in_a_row[m*W +: W] = 1000*c + m;
        in_b_col[m*W +: W] = 2000*c + m;
      end
      rdy[c] = in_ready;
      if (c < 19) step();
    end
    xfers = 0;
    low_run = 0;
    fifth = -1;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (rdy[c] !== ((c % (D + NT + 1)) < D)) begin
        n_fail++;
        $display("FAIL b2b_ready c=%0d got %b want %b", c, rdy[c], (c % (D + NT + 1)) < D);
      end
      if (rdy[c] === 1'b1) begin
        xfers++;
        if (xfers == 5) fifth = c;
      end else if (xfers == 4) begin
        low_run++;
      end
    end
    n_checks++;
    if (low_run != NT + 1 || fifth != D + NT + 1 || xfers != 2*D) begin
      n_fail++;
      $display("FAIL b2b_counts got low=%0d fifth=%0d xfers=%0d want %0d/%0d/%0d",
               low_run, fifth, xfers, NT + 1, D + NT + 1, 2*D);
    end
    for (int k = 0; k < D; k++)
      for (int m = 0; m < D; m++) begin
        ma[k][m] = 1000*(D + NT + 1 + k) + m;
        mb[m][k] = 2000*(D + NT + 1 + k) + m;
      end
    check_stream("b2b");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < D; i++)
      for (int m = 0; m < D; m++) begin
        ma[i][m] = $urandom;
        mb[i][m] = $urandom;
      end
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_a_row = row_a(k);
      in_b_col = col_b(k);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_idle("rst_mid_load");
    @(posedge clk);
    #1 rst = 1'b0;
    set_directed();
    load(0);
    check_stream("after_load_rst");
    compare_ref("after_load_rst");
    load(0);
    repeat (4) step();
    n_checks++;
    if (stream_valid !== 1'b1 || a_out !== exp_a(4)) begin
      n_fail++;
      $display("FAIL rst_pre t=4 got sv=%b a=%h want 1 %h", stream_valid, a_out, exp_a(4));
    end
    #2 rst = 1'b1;
    #1 check_idle("rst_mid_stream");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < NT + 3; c++) begin
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_done c=%0d got done=%b busy=%b want 0 0", c, done, busy);
      end
      step();
    end
    load(0);
    check_stream("after_stream_rst");
    compare_ref("after_stream_rst");
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < D; i++)
      for (int m = 0; m < D; m++) begin
        ma[i][m] = 32'hFFFF_FFFF;
        mb[i][m] = 32'hFFFF_FFFF;
      end
    load(0);
    check_stream("all_ones");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < D; i++)
        for (int m = 0; m < D; m++) begin
          ma[i][m] = $urandom;
          mb[i][m] = $urandom;
        end
      load(2);
      check_stream("random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    test_all_ones();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: element width in bits.
REQ-002 SHALL have parameter DIM, default 4: array side; square DIM x DIM operands.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: load beat offered.
REQ-006 SHALL have port in_ready, output, 1: load beat acceptable.
REQ-007 SHALL have port in_a_row, input, DIM*WIDTH: row k of A; lane m = bits [m*WIDTH +: WIDTH] = A[k][m].
REQ-008 SHALL have port in_b_col, input, DIM*WIDTH: column k of B; lane m = B[m][k].
REQ-009 SHALL have port a_out, output, DIM*WIDTH: lane i drives row i west edge of the array.
REQ-010 SHALL have port b_out, output, DIM*WIDTH: lane j drives column j north edge of the array.
REQ-011 SHALL have port stream_valid, output, 1: high every STREAM cycle.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after the last STREAM cycle.
REQ-013 SHALL have port busy, output, 1: high in STREAM and DONE.

Function
REQ-014 SHALL implement FSM states LOAD, STREAM, DONE; reset state LOAD.
REQ-015 In LOAD: in_ready=1; a beat transfers on an edge where in_valid && in_ready.
REQ-016 Beat counter k (0..DIM-1) increments per transfer; beat k stores row k of A and column k of B into internal buffers.
REQ-017 On the transfer of beat k=DIM-1: next state STREAM, k returns to 0, stream counter t=0.
REQ-018 In STREAM and DONE: in_ready=0; in_valid ignored, buffers unchanged.
REQ-019 STREAM lasts exactly 3*DIM-2 cycles; t counts 0..3*DIM-3, one per cycle.
REQ-020 In STREAM, a_out lane i = A[i][t-i] when 0 <= t-i <= DIM-1, else 0.
REQ-021 In STREAM, b_out lane j = B[t-j][j] when 0 <= t-j <= DIM-1, else 0.
REQ-022 For t >= 2*DIM-1, all lanes SHALL be 0 (drain cycles for in-flight products).
REQ-023 a_out, b_out, stream_valid SHALL be functions of registered state, buffers, and t only; no combinational path from in_* to outputs.
REQ-024 Outside STREAM, a_out=0, b_out=0, stream_valid=0.
REQ-025 When t=3*DIM-3: next state DONE; done=1 and busy=1 for exactly one cycle; then LOAD.
REQ-026 Element values SHALL pass through bit-exact; no arithmetic on data.
REQ-027 in_valid deasserted mid-load: k holds; partial load persists until completed or reset.
REQ-028 in_valid held through LOAD->STREAM->DONE->LOAD: the next transfer is the first cycle back in LOAD, stored as beat k=0.

Reset
REQ-029 While rst=1, asynchronously: state=LOAD, k=0, t=0, buffers=0, in_ready=1, a_out=0, b_out=0, stream_valid=0, done=0, busy=0.
REQ-030 Reset asserted mid-LOAD or mid-STREAM SHALL abort the operation; no done pulse; after release, the first transfer is beat k=0.

Verification
REQ-031 DIM=4, WIDTH=32, A[i][m]=16*i+m+1, B[m][j]=100+16*m+j, 4 back-to-back beats -> 10 STREAM cycles; t=0: a_out=(1,0,0,0), b_out=(100,0,0,0); t=3: a lane3=49, b lane3=103; t=6: a lane3=52, b lane3=151; t=7..9 all zero; done at cycle after t=9.
REQ-032 Same data, in_valid toggled 1,0,1,0,... -> in_ready stays 1, k advances only on valid cycles, stream identical to REQ-031.
REQ-033 in_valid held high for 20 cycles -> 4 transfers, in_ready=0 for 11 cycles (10 STREAM + DONE), fifth transfer on the first LOAD cycle, stored as beat 0.
REQ-034 rst pulsed at STREAM t=4 -> all outputs 0 immediately, no done; a subsequent full load of REQ-031 data reproduces REQ-031 exactly.
REQ-035 All-ones elements (0xFFFFFFFF) -> lanes carry 0xFFFFFFFF at their valid t windows only, 0 elsewhere; busy high for 11 cycles.
